// File: rtl/pixel_stream_reader.sv
// Raster frame-buffer reader: scans per-pixel iteration counts in address order and streams
// them as RGB888 beats with start-of-frame / end-of-line markers over a valid/ready interface.
module pixel_stream_reader #(
    parameter int H_RES    = 256,
    parameter int V_RES    = 128,
    parameter int ADDR_W   = 15,
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [ITER_W-1:0] mem_rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [23:0]       m_data,
    output logic              m_sof,
    output logic              m_eol
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int                X_W       = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam logic [X_W-1:0]    X_LAST    = X_W'(H_RES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(MAX_ITER);

    typedef struct packed {
        logic [23:0] rgb;
        logic        sof;
        logic        eol;
    } entry_t;

    function automatic logic [23:0] iter_to_rgb(input logic [ITER_W-1:0] i);
        logic [7:0] g;
        g = 8'(i);
        if (i == ITER_MAX) begin
            iter_to_rgb = 24'h000000;
        end else begin
            iter_to_rgb = {8'hFF, g, 8'h00};
        end
    endfunction

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [X_W-1:0]    x_q, x_d;
    logic              inflight_q, inflight_d;
    logic              infl_sof_q, infl_sof_d;
    logic              infl_eol_q, infl_eol_d;
    entry_t [1:0]      fifo_q, fifo_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        occ_q, occ_d;

    logic   issue_s, fifo_empty_s, pop_s, push_s, pop_fifo_s, last_beat_s;
    entry_t ret_entry_s, head_s;

    // Read issue, fall-through output selection and FIFO push/pop decisions
    always_comb begin
        fifo_empty_s = (occ_q == 2'd0);
        issue_s      = (state_q == S_RUN) && ((occ_q + {1'b0, inflight_q}) < 2'd2);
        ret_entry_s  = {iter_to_rgb(mem_rd_data), infl_sof_q, infl_eol_q};
        // Returning data is presented directly when the FIFO is empty, giving 1-cycle turnaround.
        head_s       = fifo_empty_s ? ret_entry_s : fifo_q[rd_ptr_q];
        m_valid      = !fifo_empty_s || inflight_q;
        pop_s        = m_valid && m_ready;
        push_s       = inflight_q && !(fifo_empty_s && pop_s);
        pop_fifo_s   = pop_s && !fifo_empty_s;
        last_beat_s  = pop_s && ((occ_q + {1'b0, inflight_q}) == 2'd1);
    end

    // Output port decode
    always_comb begin
        mem_rd_en = issue_s;
        mem_addr  = addr_q;
        busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
        done      = (state_q == S_DONE);
        if (m_valid) begin
            m_data = head_s.rgb;
            m_sof  = head_s.sof;
            m_eol  = head_s.eol;
        end else begin
            m_data = 24'h000000;
            m_sof  = 1'b0;
            m_eol  = 1'b0;
        end
    end

    // Scan FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
                else       state_d = S_IDLE;
            end
            S_RUN: begin
                if (issue_s && (addr_q == LAST_ADDR)) state_d = S_DRAIN;
                else                                   state_d = S_RUN;
            end
            S_DRAIN: begin
                if (last_beat_s) state_d = S_DONE;
                else             state_d = S_DRAIN;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Address / column counters, in-flight tracking and FIFO storage
    always_comb begin
        addr_d     = addr_q;
        x_d        = x_q;
        fifo_d     = fifo_q;
        inflight_d = issue_s;
        infl_sof_d = issue_s && (addr_q == {ADDR_W{1'b0}});
        infl_eol_d = issue_s && (x_q == X_LAST);
        if ((state_q == S_IDLE) && start) begin
            addr_d = {ADDR_W{1'b0}};
            x_d    = {X_W{1'b0}};
        end else if (issue_s && (addr_q != LAST_ADDR)) begin
            addr_d = addr_q + ADDR_W'(1);
            x_d    = (x_q == X_LAST) ? {X_W{1'b0}} : x_q + X_W'(1);
        end else begin
            addr_d = addr_q;
            x_d    = x_q;
        end
        if (push_s) begin
            fifo_d[wr_ptr_q] = ret_entry_s;
        end else begin
            fifo_d = fifo_q;
        end
        wr_ptr_d = wr_ptr_q ^ push_s;
        rd_ptr_d = rd_ptr_q ^ pop_fifo_s;
        case ({push_s, pop_fifo_s})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // State registers; reset discards any in-flight read and buffered pixels
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= {ADDR_W{1'b0}};
            x_q        <= {X_W{1'b0}};
            inflight_q <= 1'b0;
            infl_sof_q <= 1'b0;
            infl_eol_q <= 1'b0;
            fifo_q     <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            x_q        <= x_d;
            inflight_q <= inflight_d;
            infl_sof_q <= infl_sof_d;
            infl_eol_q <= infl_eol_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
        end
    end

endmodule

// File: tb/tb_pixel_stream_reader.sv
// Randomized bench for pixel_stream_reader: RAM model, ready driver and a beat-index scoreboard
// that predicts every pixel from the frame-buffer contents.
module tb_pixel_stream_reader;

    localparam int H_RES    = 256;
    localparam int V_RES    = 128;
    localparam int ADDR_W   = 15;
    localparam int ITER_W   = 8;
    localparam int MAX_ITER = 255;
    localparam int NPIX     = H_RES * V_RES;

    logic              clk = 1'b0;
    logic              rst, start, busy, done, mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [ITER_W-1:0] mem_rd_data;
    logic              m_valid, m_ready, m_sof, m_eol;
    logic [23:0]       m_data;

    logic [ITER_W-1:0] ram [NPIX];

    int errors = 0;
    int checks = 0;
    int acc_n = 0, iss_n = 0, sof_n = 0, eol_n = 0, done_n = 0;
    bit contig_mode = 1'b0;
    int ready_mode = 0;

    always #5 clk = ~clk;

    pixel_stream_reader #(
        .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W), .ITER_W(ITER_W), .MAX_ITER(MAX_ITER)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol)
    );

    // Synchronous frame-buffer RAM, one cycle read latency
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= ram[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] exp_rgb(input int k);
        logic [7:0] v;
        v = ram[k];
        if (v == 8'(MAX_ITER)) return 24'h000000;
        return {8'hFF, v, 8'h00};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40000; i++) begin
            if (acc_n >= n) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        check("wait_beats", hit, 1'b1);
    endtask

    task automatic wait_done();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 80000; i++) begin
            if (done) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        check("done_seen", hit, 1'b1);
    endtask

    // Downstream ready: always-on, or random 50% with a 20-cycle hold low early on
    initial begin
        int hold_cyc;
        hold_cyc = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) begin
                m_ready  = 1'b1;
                hold_cyc = 0;
            end else begin
                hold_cyc++;
                if (hold_cyc >= 200 && hold_cyc < 220) m_ready = 1'b0;
                else m_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Scoreboard: beat k must carry pixel k of the frame buffer
    initial begin
        bit          prev_stall;
        logic [25:0] prev_beat;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                acc_n = 0; iss_n = 0; sof_n = 0; eol_n = 0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", m_valid, 1'b1);
                    check("stall_hold", {m_data, m_sof, m_eol}, prev_beat);
                end
                if (mem_rd_en) begin
                    check("rd_addr", mem_addr, iss_n);
                    iss_n++;
                end
                if (m_valid && m_ready) begin
                    if (acc_n >= NPIX) begin
                        check("extra_beat", acc_n, NPIX - 1);
                    end else begin
                        check("beat_data", m_data, exp_rgb(acc_n));
                        check("beat_sof", m_sof, acc_n == 0);
                        check("beat_eol", m_eol, (acc_n % H_RES) == H_RES - 1);
                    end
                    if (m_sof) sof_n++;
                    if (m_eol) eol_n++;
                    acc_n++;
                end else if (contig_mode && acc_n > 0 && acc_n < NPIX) begin
                    check("contiguous", m_valid, 1'b1);
                end
                check("outstanding_le2", (iss_n - acc_n) <= 2, 1'b1);
                if (done) begin
                    done_n++;
                    check("done_beats", acc_n, NPIX);
                    check("done_reads", iss_n, NPIX);
                    check("done_sof_cnt", sof_n, 1);
                    check("done_eol_cnt", eol_n, V_RES);
                    check("done_busy", busy, 1'b0);
                    acc_n = 0; iss_n = 0; sof_n = 0; eol_n = 0;
                end
                prev_stall = m_valid && !m_ready;
                prev_beat  = {m_data, m_sof, m_eol};
            end
        end
    end

    initial begin
        int r;
        int d0;
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            r = $urandom_range(0, 7);
            ram[i] = (r == 0) ? 8'hFF : 8'($urandom_range(0, 255));
        end
        ram[0] = 8'hFF;
        ram[1] = 8'h00;
        ram[2] = 8'h3C;

        step();
        step();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rd_en", mem_rd_en, 1'b0);
        check("rst_addr", mem_addr, 0);
        check("rst_valid", m_valid, 1'b0);
        check("rst_data", m_data, 24'h000000);
        check("rst_markers", {m_sof, m_eol}, 2'b00);
        rst = 1'b0;
        step();

        // Full-rate frame with ignored starts mid-frame and during DONE
        contig_mode = 1'b1;
        ready_mode  = 0;
        pulse_start();
        check("lat_rd_en", mem_rd_en, 1'b1);
        check("lat_addr0", mem_addr, 0);
        check("lat_busy", busy, 1'b1);
        check("lat_no_valid", m_valid, 1'b0);
        step();
        check("lat_valid", m_valid, 1'b1);
        check("cmap_ff", m_data, 24'h000000);
        check("first_sof", m_sof, 1'b1);
        step();
        check("cmap_00", m_data, 24'hFF0000);
        step();
        check("cmap_3c", m_data, 24'hFF3C00);
        wait_beats(500);
        pulse_start();
        wait_done();
        check("done_busy_low", busy, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        check("no_restart_busy", busy, 1'b0);
        check("no_restart_valid", m_valid, 1'b0);
        check("one_done", done_n, 1);
        contig_mode = 1'b0;

        // Backpressured frame aborted by reset at beat 1000
        ready_mode = 1;
        pulse_start();
        wait_beats(1000);
        d0  = done_n;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_valid", m_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        repeat (30) step();
        check("abort_no_done", done_n, d0);

        // Rescan from address 0, backpressure for the first part of the frame
        pulse_start();
        check("rescan_rd_en", mem_rd_en, 1'b1);
        check("rescan_addr0", mem_addr, 0);
        wait_beats(3000);
        ready_mode = 0;
        wait_done();
        step();
        check("rescan_done_cnt", done_n, d0 + 1);
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
